ssd_scan_decoder: RTL and testbench
===================================

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning consecutive cycles an anode/cathode pattern must hold unchanged before it is sampled (legal range 1..65535).
REQ-002 SHALL have port ClkPort  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port An  input  4  anode lines An3..An0, active-low; An[i]=0 selects digit i.
REQ-005 SHALL have port Cath  input  8  cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, Ca in bit 7.
REQ-006 SHALL have port value  output  16  last complete decoded frame; digit i in bits [4i+3:4i].
REQ-007 SHALL have port frame_valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port digit_seen  output  4  per-digit flag: captured since last frame commit.
REQ-009 SHALL have port pattern_err  output  1  sticky: undecodable segment pattern sampled.
REQ-010 SHALL have port anode_err  output  1  sticky: more than one anode low for SETTLE_CYCLES.

Function
REQ-011 SHALL register An and Cath once at input; all decode uses registered copies (1 cycle input latency).
REQ-012 SHALL decode Cath[7:1] (abcdefg) only; Dp SHALL be ignored.
REQ-013 SHALL map abcdefg to nibble: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F; any other pattern is invalid.
REQ-014 SHALL run FSM states IDLE, SETTLE, HOLD.
REQ-015 IDLE: when registered An is one-hot-low, load settle counter with 1, go SETTLE; An=1111 stays IDLE.
REQ-016 SETTLE: any change of registered An or Cath[7:1] versus previous cycle reloads counter to 1 (stay SETTLE if still one-hot-low, else IDLE); counter reaching SETTLE_CYCLES samples the digit and goes HOLD.
REQ-017 Sample: valid pattern writes nibble into shadow[i] and sets digit_seen[i]; invalid pattern sets pattern_err, leaves shadow[i] and digit_seen[i] unchanged.
REQ-018 HOLD: no further sample until registered An or Cath[7:1] changes; then go SETTLE (one-hot-low) or IDLE.
REQ-019 Multiple anodes low (not one-hot, not 1111) stable for SETTLE_CYCLES SHALL set anode_err and sample nothing; FSM stays IDLE.
REQ-020 When digit_seen becomes 1111, next cycle SHALL copy all four shadows to value, pulse frame_valid for exactly one cycle, clear digit_seen to 0000.
REQ-021 Re-sampling an already-seen digit before commit SHALL overwrite its shadow (latest wins).
REQ-022 Commit and a new sample in the same cycle: commit uses pre-sample shadows; new sample's digit_seen bit SHALL survive the clear.
REQ-023 Settle counter SHALL be 16 bits and saturate at SETTLE_CYCLES; no wrap.
REQ-024 pattern_err and anode_err SHALL clear only on Reset.

Reset
REQ-025 Reset SHALL force FSM=IDLE, counter=0, input registers An=1111/Cath=11111111, shadows=0, value=16'h0000, frame_valid=0, digit_seen=0000, pattern_err=0, anode_err=0.
REQ-026 Reset asserted mid-SETTLE or coincident with commit SHALL win: no sample, no frame_valid pulse.
REQ-027 First sample after Reset SHALL require a full SETTLE_CYCLES window.

Verification
REQ-028 SETTLE_CYCLES=4; scan An=1110/1101/1011/0111 with patterns for 4,3,2,1, 10 cycles each -> one frame_valid pulse, value=16'h1234, digit_seen back to 0000.
REQ-029 An=1110, Cath changes every 3 cycles with SETTLE_CYCLES=4 -> no sample, digit_seen=0000, pattern_err=0.
REQ-030 An=1101, Cath=8'b11111110 held 10 cycles -> pattern_err=1, digit_seen=0000, value unchanged.
REQ-031 An=1100 held 10 cycles -> anode_err=1, digit_seen=0000; subsequent valid scan still commits.
REQ-032 Digit 0 scanned with 5 then 9 before digits 1-3 complete (A,B,C) -> value=16'hCBA9.
REQ-033 Reset pulsed during digit 3 SETTLE after digits 0-2 seen -> all outputs at reset values, no frame_valid.

Source files
------------

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder
// Recovers the four hex digits shown on a multiplexed, active-low seven-segment
// display by watching its anode and cathode lines. A digit is sampled only after
// its anode/cathode pattern has held steady for SETTLE_CYCLES cycles; once all
// four digits have been captured the frame is committed to `value`.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no single anode selected (all off, or several low: anode fault watch)
// SETTLE | one anode low, counting stable cycles before sampling the digit
// HOLD   | digit sampled, waiting for the anode/cathode pattern to move on

module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic [3:0]  An,
  input  logic [7:0]  Cath,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_seen,
  output logic        pattern_err,
  output logic        anode_err
);

  localparam logic [15:0] SETTLE_LIM = 16'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Input registers and their one-cycle-old copies for change detection
  logic [3:0]       r_an;
  logic [7:0]       r_cath;
  logic [3:0]       r_an_prev;
  logic [6:0]       r_seg_prev;

  // Control state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;

  // Captured data
  logic [3:0][3:0]  r_shadow;
  logic [15:0]      r_value;
  logic             r_frame_valid;
  logic [3:0]       r_seen;
  logic [3:0]       w_seen_nxt;
  logic             r_perr;
  logic             r_aerr;

  // Decode helpers
  logic [6:0]       w_seg;
  logic             w_changed;
  logic             w_onehot;
  logic             w_all_off;
  logic             w_multi;
  logic [1:0]       w_idx;
  logic             w_dec_valid;
  logic [3:0]       w_dec_nibble;
  logic             w_sample;
  logic             w_set_aerr;
  logic             w_commit;

  // Dp (bit 0) never takes part in decode or change detection.
  assign w_seg     = r_cath[7:1];
  assign w_changed = (r_an != r_an_prev) || (w_seg != r_seg_prev);
  assign w_all_off = (r_an == 4'b1111);
  assign w_multi   = !w_onehot && !w_all_off;
  assign w_commit  = (r_seen == 4'b1111);

  // Register the raw display lines once and keep last cycle's copy
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_an       <= 4'b1111;
      r_cath     <= 8'hFF;
      r_an_prev  <= 4'b1111;
      r_seg_prev <= 7'b1111111;
    end else begin
      r_an       <= An;
      r_cath     <= Cath;
      r_an_prev  <= r_an;
      r_seg_prev <= r_cath[7:1];
    end
  end

  // Identify a single active-low anode and which digit it selects
  always_comb begin
    w_onehot = 1'b0;
    w_idx    = 2'd0;
    case (r_an)
      4'b1110: begin w_onehot = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_onehot = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_onehot = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_onehot = 1'b1; w_idx = 2'd3; end
      default: begin w_onehot = 1'b0; w_idx = 2'd0; end
    endcase
  end

  // Map an active-low abcdefg pattern to a hex nibble
  always_comb begin
    w_dec_valid  = 1'b1;
    w_dec_nibble = 4'h0;
    case (w_seg)
      7'b0000001: w_dec_nibble = 4'h0;
      7'b1001111: w_dec_nibble = 4'h1;
      7'b0010010: w_dec_nibble = 4'h2;
      7'b0000110: w_dec_nibble = 4'h3;
      7'b1001100: w_dec_nibble = 4'h4;
      7'b0100100: w_dec_nibble = 4'h5;
      7'b0100000: w_dec_nibble = 4'h6;
      7'b0001111: w_dec_nibble = 4'h7;
      7'b0000000: w_dec_nibble = 4'h8;
      7'b0000100: w_dec_nibble = 4'h9;
      7'b0001000: w_dec_nibble = 4'hA;
      7'b1100000: w_dec_nibble = 4'hB;
      7'b0110001: w_dec_nibble = 4'hC;
      7'b1000010: w_dec_nibble = 4'hD;
      7'b0110000: w_dec_nibble = 4'hE;
      7'b0111000: w_dec_nibble = 4'hF;
      default: begin
        w_dec_valid  = 1'b0;
        w_dec_nibble = 4'h0;
      end
    endcase
  end

  // FSM state and settle counter registers
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and sample/fault strobes. The counter holds the number
  // of consecutive cycles (including the current one) the pattern has been
  // stable; it stops at SETTLE_LIM, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    w_set_aerr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_cnt_nxt   = 16'd1;
          w_state_nxt = SETTLE;
        end else if (w_multi) begin
          // Several anodes low: same stability window, but it only flags a fault.
          if (w_changed) begin
            w_cnt_nxt = 16'd1;
          end else if (r_cnt >= SETTLE_LIM) begin
            w_set_aerr = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end else begin
          w_cnt_nxt = 16'd0;
        end
      end
      SETTLE: begin
        if (w_changed) begin
          w_cnt_nxt   = w_all_off ? 16'd0 : 16'd1;
          w_state_nxt = w_onehot ? SETTLE : IDLE;
        end else if (r_cnt >= SETTLE_LIM) begin
          w_sample    = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      HOLD: begin
        if (w_changed) begin
          w_cnt_nxt   = w_all_off ? 16'd0 : 16'd1;
          w_state_nxt = w_onehot ? SETTLE : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Seen flags: a commit clears them, but a digit captured in the same cycle
  // keeps its bit so it counts toward the next frame.
  always_comb begin
    w_seen_nxt = w_commit ? 4'b0000 : r_seen;
    if (w_sample && w_dec_valid) begin
      w_seen_nxt[w_idx] = 1'b1;
    end
  end

  // Shadow capture, frame commit and sticky error flags
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_shadow      <= '0;
      r_value       <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_seen        <= 4'b0000;
      r_perr        <= 1'b0;
      r_aerr        <= 1'b0;
    end else begin
      r_seen        <= w_seen_nxt;
      r_frame_valid <= w_commit;
      // Commit reads the shadows before any same-cycle sample lands in them.
      if (w_commit) begin
        r_value <= r_shadow;
      end
      if (w_sample) begin
        if (w_dec_valid) begin
          r_shadow[w_idx] <= w_dec_nibble;
        end else begin
          r_perr <= 1'b1;
        end
      end
      if (w_set_aerr) begin
        r_aerr <= 1'b1;
      end
    end
  end

  assign value       = r_value;
  assign frame_valid = r_frame_valid;
  assign digit_seen  = r_seen;
  assign pattern_err = r_perr;
  assign anode_err   = r_aerr;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder with SETTLE_CYCLES = 4.
module tb_ssd_scan_decoder;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  digit_seen;
  logic        pattern_err;
  logic        anode_err;

  int n_vec = 0;
  int n_bad = 0;
  int frames = 0;

  ssd_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .ClkPort     (ClkPort),
    .Reset       (Reset),
    .An          (An),
    .Cath        (Cath),
    .value       (value),
    .frame_valid (frame_valid),
    .digit_seen  (digit_seen),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
  );

  always #5 ClkPort = ~ClkPort;

  // Count frame_valid high cycles; a stretched pulse shows up as extra frames.
  always @(negedge ClkPort) begin
    if (frame_valid) frames++;
  end

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  cath;
    int          cyc;
    logic [15:0] v;
    logic [3:0]  seen;
    logic        perr;
    logic        aerr;
    int          nfr;
  } vec_t;

  vec_t tbl[21];

  // Active-low cathode byte {abcdefg, dp} for a hex digit.
  function automatic logic [7:0] seg(input logic [3:0] d, input logic dp);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return {s, dp};
  endfunction

  task automatic hold(input logic [3:0] an, input logic [7:0] cath, input int n);
    An   = an;
    Cath = cath;
    repeat (n) @(posedge ClkPort);
    @(negedge ClkPort);
  endtask

  task automatic check(input string name, input logic [15:0] ev, input logic [3:0] es,
                       input logic ep, input logic ea, input logic efv, input int enf);
    n_vec++;
    if (value !== ev || digit_seen !== es || pattern_err !== ep || anode_err !== ea ||
        frame_valid !== efv || frames != enf) begin
      n_bad++;
      $display("FAIL %s: got value=%h seen=%b perr=%b aerr=%b fv=%b frames=%0d, want value=%h seen=%b perr=%b aerr=%b fv=%b frames=%0d",
               name, value, digit_seen, pattern_err, anode_err, frame_valid, frames,
               ev, es, ep, ea, efv, enf);
    end
  endtask

  initial begin
    // idle, then scan 4,3,2,1 -> 1234
    tbl[0]  = '{4'b1111, 8'hFF,        3,  16'h0000, 4'b0000, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'b1110, seg(4'h4,1), 10,  16'h0000, 4'b0001, 1'b0, 1'b0, 0};
    tbl[2]  = '{4'b1101, seg(4'h3,1), 10,  16'h0000, 4'b0011, 1'b0, 1'b0, 0};
    tbl[3]  = '{4'b1011, seg(4'h2,1), 10,  16'h0000, 4'b0111, 1'b0, 1'b0, 0};
    tbl[4]  = '{4'b0111, seg(4'h1,1), 10,  16'h1234, 4'b0000, 1'b0, 1'b0, 1};
    // cathodes change every 3 cycles: never settles
    tbl[5]  = '{4'b1110, seg(4'h7,1),  3,  16'h1234, 4'b0000, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'b1110, seg(4'h8,1),  3,  16'h1234, 4'b0000, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'b1110, seg(4'h9,1),  3,  16'h1234, 4'b0000, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'b1110, seg(4'h6,0),  3,  16'h1234, 4'b0000, 1'b0, 1'b0, 1};
    // undecodable pattern (all segments off, dp on)
    tbl[9]  = '{4'b1101, 8'b11111110, 10,  16'h1234, 4'b0000, 1'b1, 1'b0, 1};
    // two anodes low
    tbl[10] = '{4'b1100, seg(4'h5,1), 10,  16'h1234, 4'b0000, 1'b1, 1'b1, 1};
    // valid scan still commits: 8,7,6,5 -> 5678
    tbl[11] = '{4'b1110, seg(4'h8,1), 10,  16'h1234, 4'b0001, 1'b1, 1'b1, 1};
    tbl[12] = '{4'b1101, seg(4'h7,1), 10,  16'h1234, 4'b0011, 1'b1, 1'b1, 1};
    tbl[13] = '{4'b1011, seg(4'h6,1), 10,  16'h1234, 4'b0111, 1'b1, 1'b1, 1};
    tbl[14] = '{4'b0111, seg(4'h5,1), 10,  16'h5678, 4'b0000, 1'b1, 1'b1, 2};
    // digit 0 rescanned 5 then 9 (dp lit, ignored), then A,B,C -> CBA9
    tbl[15] = '{4'b1110, seg(4'h5,1), 10,  16'h5678, 4'b0001, 1'b1, 1'b1, 2};
    tbl[16] = '{4'b1110, seg(4'h9,0), 10,  16'h5678, 4'b0001, 1'b1, 1'b1, 2};
    tbl[17] = '{4'b1101, seg(4'hA,1), 10,  16'h5678, 4'b0011, 1'b1, 1'b1, 2};
    tbl[18] = '{4'b1011, seg(4'hB,1), 10,  16'h5678, 4'b0111, 1'b1, 1'b1, 2};
    tbl[19] = '{4'b0111, seg(4'hC,1), 10,  16'hCBA9, 4'b0000, 1'b1, 1'b1, 3};
    tbl[20] = '{4'b1111, 8'hFF,        5,  16'hCBA9, 4'b0000, 1'b1, 1'b1, 3};

    Reset = 1'b1;
    An    = 4'b1111;
    Cath  = 8'hFF;
    repeat (2) @(posedge ClkPort);
    @(negedge ClkPort);
    Reset = 1'b0;
    check("reset", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 21; i++) begin
      hold(tbl[i].an, tbl[i].cath, tbl[i].cyc);
      check($sformatf("row%0d", i), tbl[i].v, tbl[i].seen, tbl[i].perr, tbl[i].aerr,
            1'b0, tbl[i].nfr);
    end

    // Reset in the middle of digit 3 settling, digits 0-2 already seen
    hold(4'b1110, seg(4'h1,1), 10);
    hold(4'b1101, seg(4'h2,1), 10);
    hold(4'b1011, seg(4'h3,1), 10);
    hold(4'b0111, seg(4'h4,1), 3);
    check("pre_reset_settle", 16'hCBA9, 4'b0111, 1'b1, 1'b1, 1'b0, 3);
    Reset = 1'b1;
    @(posedge ClkPort);
    @(negedge ClkPort);
    Reset = 1'b0;
    check("reset_mid_settle", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3);

    // First sample after reset needs the full window: not yet after 5, taken on the 6th
    hold(4'b0111, seg(4'h4,1), 5);
    check("window_short", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3);
    hold(4'b0111, seg(4'h4,1), 1);
    check("window_full", 16'h0000, 4'b1000, 1'b0, 1'b0, 1'b0, 3);

    // Reset on the exact cycle the commit would happen
    hold(4'b1110, seg(4'h9,1), 10);
    check("seen_1001", 16'h0000, 4'b1001, 1'b0, 1'b0, 1'b0, 3);
    hold(4'b1101, seg(4'h8,1), 10);
    hold(4'b1011, seg(4'h7,1), 6);
    check("seen_full", 16'h0000, 4'b1111, 1'b0, 1'b0, 1'b0, 3);
    Reset = 1'b1;
    @(posedge ClkPort);
    @(negedge ClkPort);
    Reset = 1'b0;
    check("reset_on_commit", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3);
    hold(4'b1111, 8'hFF, 6);
    check("after_reset_commit", 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
